// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the transmit scheduler: FSM state encoding,
// channel index width and the default sizing of length/timing parameters.
package tx_sched_pkg;

  localparam int CH_IDX_W       = 6;
  localparam int MAX_LEN_DEF    = 39;
  localparam int LEN_W_DEF      = 6;
  localparam int IFS_CYCLES_DEF = 150;
  localparam int START_TO_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_IFS   = 3'd4
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last granted
// requester; on a tie the other one wins. Reset favours requester 0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       win
);

  logic last;

  always_comb begin
    win = (req == 2'b11) ? ~last : req[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= win;
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Two-requester transmit scheduler: arbitrates packets, streams payload into
// the tx FIFO, launches the serializer and enforces the inter-frame space.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int IFS_CYCLES = IFS_CYCLES_DEF,
  parameter int START_TO   = START_TO_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          req_valid,
  input  logic [LEN_W-1:0]    req_len0,
  input  logic [LEN_W-1:0]    req_len1,
  input  logic [CH_IDX_W-1:0] req_ch0,
  input  logic [CH_IDX_W-1:0] req_ch1,
  input  logic [31:0]         req_aa0,
  input  logic [31:0]         req_aa1,
  output logic [1:0]          gnt,
  input  logic [7:0]          byte_data0,
  input  logic [7:0]          byte_data1,
  input  logic [1:0]          byte_valid,
  output logic [1:0]          byte_ready,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic                busy,
  output logic [7:0]          txdata,
  output logic                tx_wr_en,
  output logic                txstart,
  input  logic                txready,
  output logic [CH_IDX_W-1:0] ch_idx,
  output logic [31:0]         aa
);

  localparam int TO_W  = $clog2(START_TO + 1);
  localparam int IFS_W = $clog2(IFS_CYCLES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);
  localparam logic [IFS_W-1:0] IFS_LAST = IFS_W'(IFS_CYCLES - 1);

  state_t           state;
  logic             sel;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [IFS_W-1:0] ifs_cnt;

  logic             arb_win;
  logic [LEN_W-1:0] req_len_w;
  logic             len_bad;
  logic             take;
  logic             byte_valid_w;
  logic [7:0]       byte_data_w;

  assign req_len_w    = arb_win ? req_len1 : req_len0;
  assign len_bad      = (req_len_w == '0) || (req_len_w > LEN_MAX);
  assign take         = (state == S_IDLE) && !busy && txready && (req_valid != 2'b00);
  assign byte_valid_w = sel ? byte_valid[1] : byte_valid[0];
  assign byte_data_w  = sel ? byte_data1 : byte_data0;
  assign byte_ready   = (state == S_LOAD) ? onehot2(sel) : 2'b00;

  // Pointer advances only on a real grant, not on a length reject.
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .upd (take && !len_bad),
    .win (arb_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sel      <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      to_cnt   <= '0;
      ifs_cnt  <= '0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      err      <= 2'b00;
      busy     <= 1'b0;
      txdata   <= '0;
      tx_wr_en <= 1'b0;
      txstart  <= 1'b0;
      ch_idx   <= '0;
      aa       <= '0;
    end else begin
      gnt      <= 2'b00;
      done     <= 2'b00;
      err      <= 2'b00;
      tx_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            if (len_bad) begin
              err <= onehot2(arb_win);
            end else begin
              gnt    <= onehot2(arb_win);
              sel    <= arb_win;
              len_q  <= req_len_w;
              ch_idx <= arb_win ? req_ch1 : req_ch0;
              aa     <= arb_win ? req_aa1 : req_aa0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_LOAD;
            end
          end
        end
        // Payload bytes land in the tx FIFO one cycle after the pop.
        S_LOAD: begin
          if (byte_valid_w) begin
            txdata   <= byte_data_w;
            tx_wr_en <= 1'b1;
            cnt      <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              txstart <= 1'b1;
              to_cnt  <= '0;
              state   <= S_START;
            end
          end
        end
        // txready falling is the serializer's acknowledgement of txstart.
        S_START: begin
          if (!txready) begin
            txstart <= 1'b0;
            state   <= S_WAIT;
          end else if (en) begin
            if (to_cnt == TO_LAST) begin
              err     <= onehot2(sel);
              txstart <= 1'b0;
              ifs_cnt <= '0;
              state   <= S_IFS;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (txready) begin
            done    <= onehot2(sel);
            ifs_cnt <= '0;
            state   <= S_IFS;
          end
        end
        S_IFS: begin
          if (en) begin
            if (ifs_cnt == IFS_LAST) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              ifs_cnt <= ifs_cnt + IFS_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched: randomized payloads and enable pattern, a tx serializer
// stand-in, and a packet-level reference model of arbitration and timing.
`timescale 1ns/1ps
module tb_tx_sched;
  import tx_sched_pkg::*;

  localparam int MAX_LEN    = 39;
  localparam int LEN_W      = 6;
  localparam int IFS_CYCLES = 150;
  localparam int START_TO   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [1:0]          req_valid;
  logic [LEN_W-1:0]    req_len0, req_len1;
  logic [CH_IDX_W-1:0] req_ch0, req_ch1;
  logic [31:0]         req_aa0, req_aa1;
  logic [1:0]          gnt;
  logic [7:0]          byte_data0, byte_data1;
  logic [1:0]          byte_valid;
  logic [1:0]          byte_ready;
  logic [1:0]          done;
  logic [1:0]          err;
  logic                busy;
  logic [7:0]          txdata;
  logic                tx_wr_en;
  logic                txstart;
  logic                txready;
  logic [CH_IDX_W-1:0] ch_idx;
  logic [31:0]         aa;
  logic [56:0]         outs;

  tx_sched dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_len0(req_len0), .req_len1(req_len1),
    .req_ch0(req_ch0), .req_ch1(req_ch1),
    .req_aa0(req_aa0), .req_aa1(req_aa1),
    .gnt(gnt), .byte_data0(byte_data0), .byte_data1(byte_data1),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .done(done), .err(err), .busy(busy),
    .txdata(txdata), .tx_wr_en(tx_wr_en), .txstart(txstart), .txready(txready),
    .ch_idx(ch_idx), .aa(aa)
  );

  always #5 clk = ~clk;

  assign outs = {gnt, done, err, busy, tx_wr_en, txstart, byte_ready, txdata, ch_idx, aa};

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$], q1[$], exp0[$], exp1[$], wr_q[$];
  bit         vseq0[$];
  bit         vrand = 1'b0;
  bit         tx_stuck = 1'b0;
  int         tx_hold = 0;
  int         tx_hold_len = 3;
  bit         en_used;
  int         excl_viol = 0;
  int         br_viol = 0;

  // Reference model state: last granted requester and the packet in flight.
  int                  model_last = 1;
  int                  cur_w = 0;
  logic [1:0]          cur_mask = 2'b00;
  logic [CH_IDX_W-1:0] pk_ch[2];
  logic [31:0]         pk_aa[2];

  function automatic logic [1:0] oh(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  // One clock: drive requesters and the tx stand-in, then sample after the edge.
  task automatic tick();
    bit p0, p1, s0, acc;
    en = 1'($urandom_range(0, 1));
    s0 = 1'b0;
    if (q0.size() != 0) begin
      byte_data0 = q0[0];
      if (byte_ready[0] && vseq0.size() != 0) begin
        byte_valid[0] = vseq0[0];
        s0 = 1'b1;
      end else begin
        byte_valid[0] = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end else begin
      byte_data0    = 8'h00;
      byte_valid[0] = 1'b0;
    end
    if (q1.size() != 0) begin
      byte_data1    = q1[0];
      byte_valid[1] = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      byte_data1    = 8'h00;
      byte_valid[1] = 1'b0;
    end
    p0 = byte_ready[0] && byte_valid[0];
    p1 = byte_ready[1] && byte_valid[1];
    acc = txstart && txready && en && !tx_stuck;
    en_used = en;
    @(posedge clk);
    #1;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (s0) void'(vseq0.pop_front());
    if (acc) begin
      txready = 1'b0;
      tx_hold = tx_hold_len;
    end else if (!txready) begin
      if (tx_hold == 0) txready = 1'b1;
      else tx_hold--;
    end
    if (tx_wr_en) wr_q.push_back(txdata);
    if ((gnt & err) != 2'b00) excl_viol++;
    if ((byte_ready & ~cur_mask) != 2'b00) br_viol++;
  endtask

  task automatic setup(input int r, input logic [LEN_W-1:0] len,
                       input logic [CH_IDX_W-1:0] ch, input logic [31:0] a);
    logic [7:0] b;
    pk_ch[r] = ch;
    pk_aa[r] = a;
    if (r == 0) begin
      req_len0 = len; req_ch0 = ch; req_aa0 = a;
      q0.delete(); exp0.delete();
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        q0.push_back(b); exp0.push_back(b);
      end
    end else begin
      req_len1 = len; req_ch1 = ch; req_aa1 = a;
      q1.delete(); exp1.delete();
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        q1.push_back(b); exp1.push_back(b);
      end
    end
  endtask

  task automatic request(input logic [1:0] rv);
    int w;
    logic [LEN_W-1:0] l;
    bit ok, got;
    logic [1:0] g, e;
    w  = (rv == 2'b11) ? 1 - model_last : (rv[1] ? 1 : 0);
    l  = (w == 1) ? req_len1 : req_len0;
    ok = (l >= 1) && (int'(l) <= MAX_LEN);
    cur_w    = w;
    cur_mask = ok ? oh(w) : 2'b00;
    wr_q.delete();
    req_valid = rv;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt != 2'b00 || err != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    g = gnt;
    e = err;
    req_valid = req_valid & ~(g | e);
    if (!got) begin
      tmo("resp_timeout");
    end else if (ok) begin
      chk("gnt", g, oh(w));
      chk("gnt_no_err", e, 2'b00);
      model_last = w;
      chk("ch_idx_latched", ch_idx, pk_ch[w]);
      chk("aa_latched", aa, pk_aa[w]);
    end else begin
      chk("err_len", e, oh(w));
      chk("err_no_gnt", g, 2'b00);
    end
  endtask

  task automatic wait_ifs();
    int ens, unst, stray;
    bit got;
    ens = 0; unst = 0; stray = 0; got = 1'b0;
    chk("busy_in_ifs", busy, 1);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (en_used) ens++;
      if (ch_idx !== pk_ch[cur_w] || aa !== pk_aa[cur_w]) unst++;
      if (gnt != 2'b00) stray++;
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo("ifs_timeout");
    else chk("ifs_en_cycles", ens, IFS_CYCLES);
    chk("ifs_ch_aa_stable", unst, 0);
    chk("ifs_no_gnt", stray, 0);
  endtask

  task automatic finish_pkt();
    logic [7:0] ex[$];
    int unst, stray;
    bit saw, got;
    unst = 0; stray = 0; saw = 1'b0; got = 1'b0;
    if (cur_w == 1) ex = exp1;
    else ex = exp0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ch_idx !== pk_ch[cur_w] || aa !== pk_aa[cur_w]) unst++;
      if (txstart) saw = 1'b1;
      if (gnt != 2'b00) stray++;
      if (done != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo("done_timeout");
    else chk("done", done, oh(cur_w));
    chk("txstart_seen", saw, 1);
    chk("wr_count", wr_q.size(), ex.size());
    for (int i = 0; i < ex.size() && i < wr_q.size(); i++)
      chk($sformatf("wr_byte%0d", i), wr_q[i], ex[i]);
    chk("pkt_no_gnt", stray, 0);
    chk("pkt_ch_aa_stable", unst, 0);
    wait_ifs();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_outputs", outs, 0);
    model_last = 1;
    cur_mask = 2'b00;
    req_valid = 2'b00;
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    vseq0.delete(); wr_q.delete();
    txready = 1'b1;
    tx_hold = 0;
    tick();
    tick();
    chk("rst_held_outputs", outs, 0);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    bit got, saw;
    rst = 1'b0; en = 1'b0; req_valid = 2'b00;
    req_len0 = '0; req_len1 = '0; req_ch0 = '0; req_ch1 = '0;
    req_aa0 = '0; req_aa1 = '0; byte_data0 = '0; byte_data1 = '0;
    byte_valid = 2'b00; txready = 1'b1;
    #2;
    apply_reset();
    tick();
    chk("idle_not_busy", busy, 0);

    // Directed packet with fixed payload
    setup(0, 6'd3, 6'd37, 32'h8E89BED6);
    q0 = '{8'hA1, 8'hB2, 8'hC3};
    exp0 = q0;
    request(2'b01);
    finish_pkt();

    // Both requesting: alternate grants, held request waits out the IFS
    vrand = 1'b1;
    for (int r = 0; r < 2; r++) begin
      setup(0, LEN_W'($urandom_range(1, MAX_LEN)), CH_IDX_W'($urandom_range(0, 39)), $urandom);
      setup(1, LEN_W'($urandom_range(1, MAX_LEN)), CH_IDX_W'($urandom_range(0, 39)), $urandom);
      request(2'b11);
      finish_pkt();
      request(req_valid);
      finish_pkt();
    end
    vrand = 1'b0;

    // Rejected lengths
    setup(0, 6'd0, 6'd5, 32'h11111111);
    request(2'b01);
    setup(1, 6'd40, 6'd6, 32'h22222222);
    request(2'b10);
    q1.delete();
    repeat (4) tick();
    chk("reject_no_writes", wr_q.size(), 0);
    chk("reject_not_busy", busy, 0);

    // Start timeout: serializer never acknowledges
    tx_stuck = 1'b1;
    setup(0, 6'd2, 6'd12, 32'hCAFEF00D);
    request(2'b01);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txstart) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo("to_txstart_timeout");
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (en_used) cnt++;
      if (err != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo("to_err_timeout");
    else chk("to_en_cycles", cnt, START_TO);
    chk("to_err", err, 2'b01);
    chk("to_txstart_low", txstart, 0);
    chk("to_no_done", done, 2'b00);
    chk("to_wr_count", wr_q.size(), 2);
    wait_ifs();
    tx_stuck = 1'b0;

    // Bubbly byte_valid
    setup(0, 6'd3, 6'd21, 32'h0BADBEEF);
    vseq0 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    request(2'b01);
    finish_pkt();

    // Reset during LOAD, then a tie goes to requester 0 again
    setup(0, 6'd5, 6'd3, 32'h13572468);
    vseq0 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    request(2'b01);
    tick();
    tick();
    apply_reset();
    setup(0, 6'd4, 6'd9, 32'hA5A5A5A5);
    setup(1, 6'd4, 6'd10, 32'h5A5A5A5A);
    request(2'b11);
    finish_pkt();

    // Reset during WAIT
    tx_hold_len = 25;
    request(req_valid);
    saw = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txstart) saw = 1'b1;
      if (saw && !txstart) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo("wait_reach_timeout");
    chk("wait_txready_low", txready, 0);
    apply_reset();
    tx_hold_len = 3;
    setup(0, 6'd3, 6'd30, 32'h01234567);
    setup(1, 6'd3, 6'd31, 32'h89ABCDEF);
    request(2'b11);
    finish_pkt();
    request(req_valid);
    finish_pkt();

    chk("gnt_err_exclusive", excl_viol, 0);
    chk("byte_ready_granted_only", br_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
